// File: rtl/draw_bullets_multi_if.sv
// Fire-request handshake between the game logic and the bullet engine.
// The master raises valid with x/y/dir; the engine answers with ready.
interface draw_bullets_multi_if;
    logic        valid;
    logic        ready;
    logic [10:0] x;
    logic [9:0]  y;
    logic        dir;

    modport master (output valid, output x, output y, output dir, input ready);
    modport slave  (input valid, input x, input y, input dir, output ready);
endinterface

// File: rtl/draw_bullets_multi.sv
// Multi-slot bullet engine: allocates, moves and retires up to N bullets and renders
// them as filled circles into a 12-bit pixel stream with a two-clock raster latency.
module draw_bullets_multi #(
    parameter int unsigned N     = 4,
    parameter int unsigned R     = 12,
    parameter int unsigned SPEED = 4,
    parameter int unsigned V_MAX = 479,
    parameter logic [11:0] COLOR = 12'hFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    draw_bullets_multi_if.slave  fire,
    input  logic [N-1:0]         kill_mask,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    output logic [N-1:0]         active_mask,
    output logic [11:0]          pixel
);

    localparam logic [10:0] SpeedW = 11'(SPEED);
    localparam logic [10:0] VMaxW  = 11'(V_MAX);
    localparam logic [23:0] RadSq  = 24'(R * R);

    // Slot state
    logic [N-1:0] act_q, act_d;
    logic [N-1:0] dir_q, dir_d;
    logic [10:0]  x_q [N];
    logic [10:0]  x_d [N];
    logic [9:0]   y_q [N];
    logic [9:0]   y_d [N];

    // Render pipeline
    logic signed [11:0] dx_q [N];
    logic signed [10:0] dy_q [N];
    logic [N-1:0]       act_s1_q;
    logic [10:0]        dx_mag [N];
    logic [9:0]         dy_mag [N];
    logic [23:0]        dist_sq [N];
    logic [N-1:0]       hit;

    logic [N-1:0] alloc;
    logic         alloc_found;
    logic         fire_go;

    assign fire.ready  = ~&act_q;
    assign fire_go     = fire.valid & fire.ready;
    assign active_mask = act_q;

    // Lowest-index free slot, from registered state only.
    always_comb begin
        alloc       = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!act_q[i] && !alloc_found) begin
                alloc[i]    = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        act_d = act_q;
        dir_d = dir_q;
        x_d   = x_q;
        y_d   = y_q;
        for (int i = 0; i < N; i++) begin
            if (fire_go && alloc[i]) begin
                act_d[i] = 1'b1;
                x_d[i]   = fire.x;
                y_d[i]   = fire.y;
                dir_d[i] = fire.dir;
            end else if (act_q[i]) begin
                if (kill_mask[i]) begin
                    act_d[i] = 1'b0;
                end else if (frame_tick) begin
                    if (!dir_q[i]) begin
                        if ({1'b0, y_q[i]} < SpeedW) begin
                            act_d[i] = 1'b0;
                        end else begin
                            y_d[i] = y_q[i] - SpeedW[9:0];
                        end
                    end else begin
                        // 11-bit sum so a bottom-edge overflow cannot wrap into range
                        if (({1'b0, y_q[i]} + SpeedW) > VMaxW) begin
                            act_d[i] = 1'b0;
                        end else begin
                            y_d[i] = y_q[i] + SpeedW[9:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
            dir_q <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q <= act_d;
            dir_q <= dir_d;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    // S1: per-slot signed offsets of the raster position from each bullet centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_s1_q <= '0;
            for (int i = 0; i < N; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            act_s1_q <= act_q;
            for (int i = 0; i < N; i++) begin
                dx_q[i] <= $signed({1'b0, hcount}) - $signed({1'b0, x_q[i]});
                dy_q[i] <= $signed({1'b0, vcount}) - $signed({1'b0, y_q[i]});
            end
        end
    end

    // S2: squares of magnitudes, so the sum never wraps in 24 bits.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            dx_mag[i]  = dx_q[i][11] ? 11'(-dx_q[i]) : dx_q[i][10:0];
            dy_mag[i]  = dy_q[i][10] ? 10'(-dy_q[i]) : dy_q[i][9:0];
            dist_sq[i] = (24'(dx_mag[i]) * 24'(dx_mag[i])) + (24'(dy_mag[i]) * 24'(dy_mag[i]));
            hit[i]     = act_s1_q[i] && (dist_sq[i] <= RadSq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= '0;
        end else begin
            pixel <= (|hit) ? COLOR : 12'h000;
        end
    end

endmodule

// File: tb/tb_draw_bullets_multi.sv
// Directed bench for draw_bullets_multi: an abstract slot/circle model is checked every
// cycle, alongside hand-computed expectations for the key scenarios.
module tb_draw_bullets_multi;

    localparam int N     = 4;
    localparam int R     = 12;
    localparam int SPEED = 4;
    localparam int V_MAX = 479;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick;
    logic [N-1:0]  kill_mask;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [N-1:0]  active_mask;
    logic [11:0]   pixel;

    int errors = 0;
    int checks = 0;

    draw_bullets_multi_if fire_if ();

    draw_bullets_multi #(
        .N     (N),
        .R     (R),
        .SPEED (SPEED),
        .V_MAX (V_MAX),
        .COLOR (12'hFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .fire        (fire_if),
        .kill_mask   (kill_mask),
        .hcount      (hcount),
        .vcount      (vcount),
        .active_mask (active_mask),
        .pixel       (pixel)
    );

    always #5 clk = ~clk;

    // Abstract model: slot table plus a two-stage delay of the circle-coverage result.
    bit          m_act [N];
    int          m_x   [N];
    int          m_y   [N];
    bit          m_dir [N];
    logic [11:0] m_s1;
    logic [11:0] m_pix;

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [11:0] model_pixel(int h, int v);
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && ((h - m_x[i]) * (h - m_x[i]) + (v - m_y[i]) * (v - m_y[i])) <= R * R)
                return 12'hFFF;
        end
        return 12'h000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] <= 1'b0;
                m_x[i]   <= 0;
                m_y[i]   <= 0;
                m_dir[i] <= 1'b0;
            end
            m_s1  <= 12'h000;
            m_pix <= 12'h000;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fire_if.valid && lowest_free() == i) begin
                    m_act[i] <= 1'b1;
                    m_x[i]   <= int'(fire_if.x);
                    m_y[i]   <= int'(fire_if.y);
                    m_dir[i] <= fire_if.dir;
                end else if (m_act[i] && kill_mask[i]) begin
                    m_act[i] <= 1'b0;
                end else if (m_act[i] && frame_tick) begin
                    if (m_dir[i]) begin
                        if (m_y[i] + SPEED > V_MAX) m_act[i] <= 1'b0;
                        else m_y[i] <= m_y[i] + SPEED;
                    end else begin
                        if (m_y[i] - SPEED < 0) m_act[i] <= 1'b0;
                        else m_y[i] <= m_y[i] - SPEED;
                    end
                end
            end
            m_s1  <= model_pixel(int'(hcount), int'(vcount));
            m_pix <= m_s1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("active_mask", 32'(active_mask), 32'(model_mask()));
        chk("fire_ready", 32'(fire_if.ready), 32'(model_mask() != '1));
        chk("pixel", 32'(pixel), 32'(m_pix));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic fire_once(input int x, input int y, input bit dir);
        fire_if.valid = 1'b1;
        fire_if.x     = 11'(x);
        fire_if.y     = 10'(y);
        fire_if.dir   = dir;
        step();
        fire_if.valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [11:0] exp);
        hcount = 11'(h);
        vcount = 10'(v);
        step();
        step();
        chk(name, 32'(pixel), 32'(exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        frame_tick    = 1'b0;
        kill_mask     = '0;
        hcount        = '0;
        vcount        = '0;
        fire_if.valid = 1'b0;
        fire_if.x     = '0;
        fire_if.y     = '0;
        fire_if.dir   = 1'b0;
        step();
        chk("reset_mask", 32'(active_mask), 32'h0);
        chk("reset_pixel", 32'(pixel), 32'h0);
        chk("reset_ready", 32'(fire_if.ready), 32'h1);
        rst_n = 1'b1;
        step();

        // 1: single bullet and its circle footprint
        fire_once(100, 200, 1'b0);
        chk("t1_mask", 32'(active_mask), 32'b0001);
        probe("t1_centre", 100, 200, 12'hFFF);
        probe("t1_right_out", 113, 200, 12'h000);
        probe("t1_below_edge", 100, 212, 12'hFFF);

        // 2: fill all slots, ignored fire, kill and reuse
        fire_once(300, 100, 1'b1);
        fire_once(400, 300, 1'b0);
        fire_once(500, 50, 1'b1);
        chk("t2_full_ready", 32'(fire_if.ready), 32'h0);
        chk("t2_full_mask", 32'(active_mask), 32'b1111);
        fire_once(600, 60, 1'b0);
        chk("t2_ignored_mask", 32'(active_mask), 32'b1111);
        probe("t2_ignored_pix", 600, 60, 12'h000);
        kill_mask = 4'b0100;
        fire_if.valid = 1'b1;
        fire_if.x = 11'd650;
        fire_if.y = 10'd65;
        step();
        fire_if.valid = 1'b0;
        kill_mask = '0;
        chk("t2_killed_mask", 32'(active_mask), 32'b1011);
        fire_once(700, 70, 1'b0);
        chk("t2_refill_mask", 32'(active_mask), 32'b1111);
        probe("t2_refill_pix", 700, 70, 12'hFFF);
        probe("t2_old_slot2", 400, 300, 12'h000);

        // 3: upward bullet retired at the top edge
        do_reset();
        fire_once(50, 6, 1'b0);
        tick();
        probe("t3_y2_edge", 50, 14, 12'hFFF);
        probe("t3_y2_out", 50, 15, 12'h000);
        tick();
        chk("t3_retired", 32'(active_mask), 32'b0000);

        // 4: downward bullets at the bottom edge
        do_reset();
        fire_once(60, 476, 1'b1);
        fire_once(80, 475, 1'b1);
        tick();
        chk("t4_mask", 32'(active_mask), 32'b0010);
        probe("t4_y479", 80, 479, 12'hFFF);
        probe("t4_top_edge", 80, 467, 12'hFFF);
        probe("t4_top_out", 80, 466, 12'h000);

        // 5: fire coincident with frame_tick
        do_reset();
        fire_once(200, 100, 1'b1);
        fire_if.valid = 1'b1;
        fire_if.x = 11'd220;
        fire_if.y = 10'd150;
        fire_if.dir = 1'b0;
        frame_tick = 1'b1;
        step();
        fire_if.valid = 1'b0;
        frame_tick = 1'b0;
        chk("t5_mask", 32'(active_mask), 32'b0011);
        probe("t5_moved", 200, 104, 12'hFFF);
        probe("t5_moved_top", 200, 92, 12'hFFF);
        probe("t5_moved_out", 200, 91, 12'h000);
        probe("t5_new_edge", 220, 162, 12'hFFF);
        probe("t5_new_out", 220, 163, 12'h000);

        // 6: no wrap-around hit, then asynchronous reset mid-line
        do_reset();
        fire_once(5, 300, 1'b0);
        probe("t6_far_right", 1000, 300, 12'h000);
        probe("t6_left_of_x", 0, 300, 12'hFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pixel", 32'(pixel), 32'h0);
        chk("t6_async_mask", 32'(active_mask), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Raster sweep with motion, a kill and a mid-sweep fire; model checked every cycle.
        fire_once(100, 200, 1'b0);
        fire_once(150, 205, 1'b1);
        fire_once(180, 195, 1'b0);
        for (int i = 0; i < 120; i++) begin
            hcount = 11'(90 + i);
            vcount = 10'(196 + (i % 12));
            frame_tick = (i % 10 == 9);
            kill_mask = (i == 60) ? 4'b0010 : 4'b0000;
            fire_if.valid = (i == 30);
            fire_if.x = 11'd160;
            fire_if.y = 10'd200;
            fire_if.dir = 1'b1;
            step();
        end
        frame_tick = 1'b0;
        kill_mask = '0;
        fire_if.valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
